// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential ALU.
//   - opcode constants OP_ADD .. OP_NOP (4-bit)
//   - controller state type (IDLE, BUSY)
//   - is_iterative(): decides whether an accepted op needs the multi-cycle unit
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_INC  = 4'd2;
  localparam logic [3:0] OP_DEC  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_ASR  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_PASS = 4'd13;
  localparam logic [3:0] OP_CMP  = 4'd14;
  localparam logic [3:0] OP_NOP  = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Shift amount is passed zero-extended to 6 bits, enough for WIDTH up to 64.
  // A shift/rotate by zero is finished in the accept cycle, so only a
  // non-zero amount (or any multiply) goes through the iterative unit.
  function automatic logic is_iterative(input logic [3:0] op, input logic [5:0] shamt);
    case (op)
      OP_SHL, OP_SHR, OP_ASR, OP_ROL: return (shamt != 6'd0);
      OP_MUL:                         return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: multi-cycle engine for shifts, rotates and multiply.
//   clk, rst          clock, synchronous active-high reset
//   start             load operands and begin (one-cycle strobe)
//   op, a, b          opcode and operands, sampled on start
//   done              high during the last step; res_* then hold the final result
//   res_lo, res_hi    value of the working registers after the current step
//   res_c             bit shifted out by the current step (0 for MUL)
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             res_c
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = SHAMT_W + 1;

  logic [3:0]       op_r;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   mul_sum;

  // The step that cnt == 1 is about to perform is the final one, so the
  // owner can write res_* on this same edge.
  assign done = (cnt == CNT_W'(1));

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    res_hi  = w_hi;
    res_lo  = w_lo;
    res_c   = 1'b0;
    mul_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, mcand} : '0);
    case (op_r)
      OP_SHL: begin
        res_lo = {w_lo[WIDTH-2:0], 1'b0};
        res_c  = w_lo[WIDTH-1];
      end
      OP_SHR: begin
        res_lo = {1'b0, w_lo[WIDTH-1:1]};
        res_c  = w_lo[0];
      end
      OP_ASR: begin
        res_lo = {w_lo[WIDTH-1], w_lo[WIDTH-1:1]};
        res_c  = w_lo[0];
      end
      OP_ROL: begin
        res_lo = {w_lo[WIDTH-2:0], w_lo[WIDTH-1]};
        res_c  = w_lo[WIDTH-1];
      end
      OP_MUL: begin
        // Shift-add: {w_hi, w_lo} starts as {0, b}; each step conditionally
        // adds the multiplicand to the high half, then shifts right by one.
        res_hi = mul_sum[WIDTH:1];
        res_lo = {mul_sum[0], w_lo[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= (op == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(b[SHAMT_W-1:0]);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on start
  // before being observed, and cnt alone decides whether they are live.
  always_ff @(posedge clk) begin
    if (start) begin
      op_r  <= op;
      mcand <= a;
      w_hi  <= '0;
      w_lo  <= (op == OP_MUL) ? b : a;
    end else if (cnt != '0) begin
      w_hi  <= res_hi;
      w_lo  <= res_lo;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked, parametrised ALU with registered result and flags.
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_ready  operand handshake; in_ready is high exactly when idle
//   op, a, b            opcode and operands (b low bits = shift amount)
//   out_valid           one-cycle pulse marking the cycle f/flags were updated
//   f, f_hi             result, upper product half (MUL only, else cleared)
//   Z, C, V             zero, carry/borrow, signed overflow
//   eq, gr, ls          a vs b compare captured at accept
// Single-cycle ops finish on the accept edge; shifts/rotates by n > 0 and MUL
// are handed to alu_seq_iter and finish n or WIDTH edges later.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] f_hi,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             eq,
  output logic             gr,
  output logic             ls
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int MSB     = WIDTH - 1;

  state_t             state;
  logic               accept;
  logic               start;
  logic [SHAMT_W-1:0] shamt;

  logic               is_sub;
  logic [WIDTH-1:0]   opnd_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   sc_f;
  logic               sc_c;
  logic               sc_v;
  logic               sc_wr_f;
  logic               sc_wr_flags;

  logic               cmp_eq;
  logic               cmp_gr;
  logic               cmp_ls;

  logic               iter_done;
  logic [WIDTH-1:0]   iter_lo;
  logic [WIDTH-1:0]   iter_hi;
  logic               iter_c;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign shamt    = b[SHAMT_W-1:0];
  assign start    = accept & is_iterative(op, 6'(shamt));

  always_comb begin
    cmp_eq = (a == b);
    if (SIGNED_CMP) begin
      cmp_gr = ($signed(a) > $signed(b));
      cmp_ls = ($signed(a) < $signed(b));
    end else begin
      cmp_gr = (a > b);
      cmp_ls = (a < b);
    end
  end

  // One WIDTH+1 adder serves ADD/SUB/INC/DEC/CMP; its top bit is the carry,
  // or the borrow (a < operand, unsigned) when subtracting.
  always_comb begin
    is_sub      = (op == OP_SUB) || (op == OP_CMP) || (op == OP_DEC);
    opnd_b      = ((op == OP_INC) || (op == OP_DEC)) ? WIDTH'(1) : b;
    sum         = is_sub ? ({1'b0, a} - {1'b0, opnd_b}) : ({1'b0, a} + {1'b0, opnd_b});
    sc_f        = sum[WIDTH-1:0];
    sc_c        = 1'b0;
    sc_v        = 1'b0;
    sc_wr_f     = 1'b1;
    sc_wr_flags = 1'b1;
    case (op)
      OP_ADD, OP_INC: begin
        sc_c = sum[WIDTH];
        sc_v = (a[MSB] == opnd_b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB, OP_DEC, OP_CMP: begin
        sc_c    = sum[WIDTH];
        sc_v    = (a[MSB] != opnd_b[MSB]) && (sum[MSB] != a[MSB]);
        sc_wr_f = (op != OP_CMP);
      end
      OP_AND:  sc_f = a & b;
      OP_OR:   sc_f = a | b;
      OP_XOR:  sc_f = a ^ b;
      OP_NOT:  sc_f = ~a;
      OP_PASS: sc_f = b;
      OP_NOP: begin
        sc_wr_f     = 1'b0;
        sc_wr_flags = 1'b0;
      end
      // Shifts/rotates by zero pass a through; MUL never completes here.
      default: sc_f = a;
    endcase
  end

  alu_seq_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .done   (iter_done),
    .res_lo (iter_lo),
    .res_hi (iter_hi),
    .res_c  (iter_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      f         <= '0;
      f_hi      <= '0;
      Z         <= 1'b0;
      C         <= 1'b0;
      V         <= 1'b0;
      eq        <= 1'b0;
      gr        <= 1'b0;
      ls        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          eq <= cmp_eq;
          gr <= cmp_gr;
          ls <= cmp_ls;
          if (start) begin
            state <= BUSY;
          end else begin
            out_valid <= 1'b1;
            if (sc_wr_f) begin
              f    <= sc_f;
              f_hi <= '0;
            end
            if (sc_wr_flags) begin
              Z <= (sc_f == '0);
              C <= sc_c;
              V <= sc_v;
            end
          end
        end
      end else if (iter_done) begin
        // Shifts keep iter_hi at zero, so the MUL-style Z/V rules cover both.
        state     <= IDLE;
        out_valid <= 1'b1;
        f         <= iter_lo;
        f_hi      <= iter_hi;
        Z         <= ({iter_hi, iter_lo} == '0);
        C         <= iter_c;
        V         <= (iter_hi != '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq.
// Three instances: 8-bit unsigned compare (main), 8-bit signed compare sharing
// the main inputs, and a 16-bit unit for the wide-shift corner case.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic [3:0] op;
  logic [7:0] a, b;
  logic       in_ready, out_valid;
  logic [7:0] f, f_hi;
  logic       Z, C, V, eq, gr, ls;

  logic       s_in_ready, s_out_valid;
  logic [7:0] s_f, s_f_hi;
  logic       s_Z, s_C, s_V, s_eq, s_gr, s_ls;

  logic        w_valid;
  logic [3:0]  w_op;
  logic [15:0] w_a, w_b;
  logic        w_ready, w_out_valid;
  logic [15:0] w_f, w_f_hi;
  logic        w_Z, w_C, w_V, w_eq, w_gr, w_ls;

  alu_seq #(.WIDTH(8), .SIGNED_CMP(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .f(f), .f_hi(f_hi),
    .Z(Z), .C(C), .V(V), .eq(eq), .gr(gr), .ls(ls)
  );

  alu_seq #(.WIDTH(8), .SIGNED_CMP(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .op(op),
    .a(a), .b(b), .out_valid(s_out_valid), .f(s_f), .f_hi(s_f_hi),
    .Z(s_Z), .C(s_C), .V(s_V), .eq(s_eq), .gr(s_gr), .ls(s_ls)
  );

  alu_seq #(.WIDTH(16), .SIGNED_CMP(1'b0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(w_ready), .op(w_op),
    .a(w_a), .b(w_b), .out_valid(w_out_valid), .f(w_f), .f_hi(w_f_hi),
    .Z(w_Z), .C(w_C), .V(w_V), .eq(w_eq), .gr(w_gr), .ls(w_ls)
  );

  // flg packs {Z, C, V, eq, gr, ls}; lat = edges from accept to result.
  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] f;
    logic [7:0] fhi;
    logic [5:0] flg;
    int         lat;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: results straight from the opcode definitions using
  // integer arithmetic; prev supplies what CMP/NOP leave untouched.
  function automatic vec_t model(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                                 input vec_t prev);
    vec_t r;
    int ua, ub, sa, sb, n, res, sres;
    logic z, c, v;
    r  = prev;
    ua = int'(xa);
    ub = int'(xb);
    sa = $signed(xa);
    sb = $signed(xb);
    n  = ub % 8;
    res = 0;
    z = prev.flg[5];
    c = prev.flg[4];
    v = prev.flg[3];
    r.op = o; r.a = xa; r.b = xb; r.lat = 0;
    case (o)
      OP_ADD:         begin res = ua + ub; c = (res > 255); sres = sa + sb; v = (sres > 127) || (sres < -128); end
      OP_SUB, OP_CMP: begin res = ua - ub; c = (ua < ub);   sres = sa - sb; v = (sres > 127) || (sres < -128); end
      OP_INC:         begin res = ua + 1;  c = (res > 255); v = (sa + 1 > 127); end
      OP_DEC:         begin res = ua - 1;  c = (ua < 1);    v = (sa - 1 < -128); end
      OP_AND:         begin res = ua & ub; c = 1'b0; v = 1'b0; end
      OP_OR:          begin res = ua | ub; c = 1'b0; v = 1'b0; end
      OP_XOR:         begin res = ua ^ ub; c = 1'b0; v = 1'b0; end
      OP_NOT:         begin res = 255 - ua; c = 1'b0; v = 1'b0; end
      OP_SHL:         begin res = ua << n; c = (n > 0) && (((res >> 8) & 1) == 1); v = 1'b0; r.lat = n; end
      OP_SHR:         begin res = ua >> n; c = (n > 0) && (((ua >> (n - 1)) & 1) == 1); v = 1'b0; r.lat = n; end
      OP_ASR:         begin res = sa >>> n; c = (n > 0) && (((ua >> (n - 1)) & 1) == 1); v = 1'b0; r.lat = n; end
      OP_ROL:         begin res = ((ua << n) | (ua >> (8 - n))) & 255; c = (n > 0) && ((res & 1) == 1); v = 1'b0; r.lat = n; end
      OP_MUL:         begin res = ua * ub; c = 1'b0; v = (res > 255); r.lat = 8; end
      OP_PASS:        begin res = ub; c = 1'b0; v = 1'b0; end
      default: ;
    endcase
    if (o != OP_NOP) begin
      if (o != OP_CMP) begin
        r.f   = 8'(res & 255);
        r.fhi = (o == OP_MUL) ? 8'(res >> 8) : 8'h00;
      end
      z = (o == OP_MUL) ? (res == 0) : ((res & 255) == 0);
    end
    r.flg = {z, c, v, ua == ub, ua > ub, ua < ub};
    return r;
  endfunction

  // Issue one op on the 8-bit pair and wait (bounded) for out_valid. While the
  // unit is busy, junk requests are offered to show they are ignored.
  task automatic do_op(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                       output int lat, output int low);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    op = o; a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    low = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) low++;
      in_valid = 1'b1;
      op = 4'($urandom);
      a  = 8'($urandom);
      b  = 8'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  vec_t tbl[$];
  vec_t exp_v;

  initial begin
    int lat, low, nv;
    logic [3:0] ro;
    logic [7:0] ra, rb, sum8;

    tbl.push_back('{OP_ADD,  8'hFF, 8'h01, 8'h00, 8'h00, 6'b110_010, 0});
    tbl.push_back('{OP_SUB,  8'h80, 8'h01, 8'h7F, 8'h00, 6'b001_010, 0});
    tbl.push_back('{OP_CMP,  8'h05, 8'h05, 8'h7F, 8'h00, 6'b100_100, 0});
    tbl.push_back('{OP_SHL,  8'h81, 8'h03, 8'h08, 8'h00, 6'b000_010, 3});
    tbl.push_back('{OP_ASR,  8'h80, 8'h01, 8'hC0, 8'h00, 6'b000_010, 1});
    tbl.push_back('{OP_MUL,  8'h0F, 8'h11, 8'hFF, 8'h00, 6'b000_001, 8});
    tbl.push_back('{OP_MUL,  8'hFF, 8'hFF, 8'h01, 8'hFE, 6'b001_100, 8});
    tbl.push_back('{OP_NOP,  8'h00, 8'h00, 8'h01, 8'hFE, 6'b001_100, 0});
    tbl.push_back('{OP_SHR,  8'h81, 8'h00, 8'h81, 8'h00, 6'b000_010, 0});
    tbl.push_back('{OP_ROL,  8'h81, 8'h01, 8'h03, 8'h00, 6'b010_010, 1});
    tbl.push_back('{OP_SUB,  8'h00, 8'h01, 8'hFF, 8'h00, 6'b010_001, 0});
    tbl.push_back('{OP_INC,  8'h7F, 8'h00, 8'h80, 8'h00, 6'b001_010, 0});
    tbl.push_back('{OP_DEC,  8'h00, 8'h00, 8'hFF, 8'h00, 6'b010_100, 0});
    tbl.push_back('{OP_NOT,  8'h0F, 8'hF0, 8'hF0, 8'h00, 6'b000_001, 0});
    tbl.push_back('{OP_SHL,  8'hFF, 8'h07, 8'h80, 8'h00, 6'b010_010, 7});
    tbl.push_back('{OP_PASS, 8'h00, 8'h00, 8'h00, 8'h00, 6'b100_100, 0});
    tbl.push_back('{OP_XOR,  8'hAA, 8'hAA, 8'h00, 8'h00, 6'b100_100, 0});

    rst = 1'b1; in_valid = 1'b0; op = 4'd0; a = 8'd0; b = 8'd0;
    w_valid = 1'b0; w_op = 4'd0; w_a = 16'd0; w_b = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst f", f, 8'h00);
    check("rst f_hi", f_hi, 8'h00);
    check("rst flags", {Z, C, V, eq, gr, ls}, 6'b0);
    check("rst out_valid", out_valid, 1'b0);
    check("rst in_ready", in_ready, 1'b1);

    // Directed vectors
    for (int i = 0; i < tbl.size(); i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, low);
      check($sformatf("vec%0d f", i), f, tbl[i].f);
      check($sformatf("vec%0d f_hi", i), f_hi, tbl[i].fhi);
      check($sformatf("vec%0d ZCV/eq/gr/ls", i), {Z, C, V, eq, gr, ls}, tbl[i].flg);
      check($sformatf("vec%0d latency", i), lat, tbl[i].lat);
      check($sformatf("vec%0d busy cycles", i), low, tbl[i].lat);
      check($sformatf("vec%0d ready at done", i), in_ready, 1'b1);
      check($sformatf("vec%0d signed cmp", i), {s_eq, s_gr, s_ls},
            {tbl[i].a == tbl[i].b, $signed(tbl[i].a) > $signed(tbl[i].b),
             $signed(tbl[i].a) < $signed(tbl[i].b)});
      @(posedge clk); #1;
      check($sformatf("vec%0d pulse width", i), out_valid, 1'b0);
    end

    // Randomized ops against the reference model
    exp_v = tbl[tbl.size() - 1];
    for (int i = 0; i < 80; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = 8'($urandom);
      exp_v = model(ro, ra, rb, exp_v);
      do_op(ro, ra, rb, lat, low);
      check($sformatf("rnd%0d op%0d f", i, ro), f, exp_v.f);
      check($sformatf("rnd%0d op%0d f_hi", i, ro), f_hi, exp_v.fhi);
      check($sformatf("rnd%0d op%0d flags", i, ro), {Z, C, V, eq, gr, ls}, exp_v.flg);
      check($sformatf("rnd%0d op%0d latency", i, ro), lat, exp_v.lat);
    end

    // Reset in the middle of a multiply aborts it
    do_op(OP_ADD, 8'h01, 8'h01, lat, low);
    check("pre-abort f", f, 8'h02);
    @(negedge clk);
    op = OP_MUL; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort out_valid", out_valid, 1'b0);
    check("abort f", f, 8'h00);
    check("abort f_hi", f_hi, 8'h00);
    check("abort flags", {Z, C, V, eq, gr, ls}, 6'b0);
    check("abort in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) nv++;
    end
    check("abort no late result", nv, 0);

    // Back-to-back ADD stream: one result every cycle
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ra = 8'($urandom);
      rb = 8'($urandom);
      sum8 = 8'((int'(ra) + int'(rb)) & 255);
      op = OP_ADD; a = ra; b = rb; in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("stream%0d out_valid", i), out_valid, 1'b1);
      check($sformatf("stream%0d f", i), f, sum8);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream end out_valid", out_valid, 1'b0);

    // 16-bit: SHR 8000 by 15 finishes 15 edges after accept
    @(negedge clk);
    w_op = OP_SHR; w_a = 16'h8000; w_b = 16'h000F; w_valid = 1'b1;
    @(posedge clk); #1;
    w_valid = 1'b0;
    w_a = 16'h1234;
    w_b = 16'h0003;
    lat = 0;
    while (!w_out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w16 latency", lat, 15);
    check("w16 f", w_f, 16'h0001);
    check("w16 f_hi", w_f_hi, 16'h0000);
    check("w16 ZCV", {w_Z, w_C, w_V}, 3'b000);
    check("w16 in_ready", w_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the 8-bit registered ALU. Single-cycle arithmetic and logic ops complete in one clock. Shifts, rotates and multiply run iteratively, one step per clock, through a sub-unit. The result register and flags sit between the operand source (register file / test harness) and the writeback stage.

Parameters:
WIDTH, 8, operand/result width; power of two, 4..64; SHAMT_W = $clog2(WIDTH) is derived locally.
SIGNED_CMP, 0, 0 = eq/gr/ls compare unsigned; 1 = compare two's-complement signed.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous active-high reset; sampled on the rising edge of clk.
in_valid  in  1  operand/opcode valid.
in_ready  out  1  block can accept; equals (state == IDLE).
op  in  4  opcode, encoded per the package constants.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B; low SHAMT_W bits give the shift amount for shift/rotate ops.
out_valid  out  1  one-cycle pulse; f and flags are updated in this cycle.
f  out  WIDTH  result register.
f_hi  out  WIDTH  upper product half (MUL only).
Z, C, V  out  1 each  zero, carry/borrow, overflow flags (registered).
eq, gr, ls  out  1 each  compare of a vs b captured at accept (registered).

Behaviour:
- Reset:
  - f = f_hi = 0; all flags = 0; out_valid = 0; state = IDLE; in_ready = 1.
  - Reset mid-operation aborts the op. No out_valid is produced.
- Accept: in_valid & in_ready at edge k. a, b and op are captured. Callers need not hold them afterwards.
- eq/gr/ls: updated at edge k for every accepted op, including NOP.
- Opcodes:
  - 0 ADD, 1 SUB, 2 INC (a+1), 3 DEC (a-1)
  - 4 AND, 5 OR, 6 XOR, 7 NOT (~a)
  - 8 SHL, 9 SHR, 10 ASR, 11 ROL
  - 12 MUL (unsigned, 2*WIDTH-bit product)
  - 13 PASS (f = b)
  - 14 CMP: flags as SUB; f and f_hi unchanged
  - 15 NOP: f, f_hi, Z/C/V unchanged; out_valid still pulses
- Single-cycle ops (0-7, 13-15, and shifts with n = b[SHAMT_W-1:0] == 0):
  - Result and out_valid at edge k; state stays IDLE.
  - For n == 0: f = a, C = 0.
- Iterative ops:
  - Shift/rotate with n > 0: result at edge k+n.
  - MUL: result at edge k+WIDTH.
  - in_ready = 0 during BUSY. in_valid is ignored while BUSY.
  - The final BUSY edge returns to IDLE, so in_ready = 1 in the out_valid cycle. Back-to-back issue is allowed.
- FSM:
  - IDLE -> BUSY on accepting an iterative op; cnt loaded with n or WIDTH.
  - BUSY: one step per edge, cnt decrements; at cnt == 1 the result is written, out_valid is set, and state goes to IDLE.
- Flags:
  - Z: f == 0; for MUL, {f_hi, f} == 0.
  - C: carry out for ADD/INC; borrow (a < b unsigned) for SUB/CMP/DEC; last bit shifted out for shifts/ROL; 0 for logic ops, PASS and MUL.
  - V: signed overflow for ADD/SUB/INC/DEC/CMP; for MUL, f_hi != 0; 0 otherwise.
- f_hi: written with the product high half by MUL; cleared to 0 by every other op that writes f.
- Widths: internal sums are WIDTH+1 bits. ASR replicates the MSB. ROL rotates the MSB into the LSB.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams (OP_ADD..OP_NOP)
  - state enum (IDLE, BUSY)
  - function is_iterative(op, shamt)
- One sub-module, alu_seq_iter, holds:
  - working registers, shift/rotate step and shift-add multiply step
  - cnt and done signal
- The top level holds the handshake, single-cycle datapath, flag logic and output registers.

Test Plan:
- WIDTH=8, ADD a=FF b=01 -> next cycle f=00, Z=1, C=1, V=0, eq=0, gr=1; out_valid pulses 1 cycle.
- SUB a=80 b=01 -> f=7F, V=1, C=0, gr=1. CMP a=05 b=05 -> eq=1, Z=1, f unchanged.
- SHL a=81 b=03 -> in_ready low 3 cycles; result at edge k+3: f=08, C=0. ASR a=80 b=01 -> f=C0.
- MUL a=0F b=11 -> result at edge k+8: f=FF, f_hi=00, V=0. MUL a=FF b=FF -> f=01, f_hi=FE, V=1.
- Assert rst on the 4th cycle of MUL -> no out_valid; f=0, flags=0, in_ready=1 next cycle. Then continuous ADD stream -> one out_valid per cycle.
- SIGNED_CMP=1, a=80 b=01 -> ls=1, gr=0. WIDTH=16 SHR a=8000 b=000F -> f=0001 at edge k+15.
